// File: rtl/conv_window_gen.sv
// Sliding-window generator: raster pixel stream in, flattened WIN_SIZE x WIN_SIZE windows out.
// Line buffers feed the window's right-hand column; windows touching a line or frame edge are suppressed.

module conv_line_buf #(
    parameter int DIN_WIDTH = 8,
    parameter int DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [DIN_WIDTH-1:0] din,
    output logic [DIN_WIDTH-1:0] dout
);
    logic [DEPTH-1:0][DIN_WIDTH-1:0] mem;

    // Contents are never observed before being overwritten, so no reset.
    always_ff @(posedge clk) begin
        if (en) mem <= {mem[DEPTH-2:0], din};
    end

    assign dout = mem[DEPTH-1];
endmodule

module conv_window_gen #(
    parameter int DIN_WIDTH  = 8,
    parameter int WIN_SIZE   = 3,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         pix_vld,
    input  logic                                         pix_sof,
    input  logic [DIN_WIDTH-1:0]                         pix,
    output logic                                         win_vld,
    output logic [WIN_SIZE*WIN_SIZE-1:0][DIN_WIDTH-1:0]  win,
    output logic                                         win_last
);
    localparam int WIN_SQR = WIN_SIZE * WIN_SIZE;
    localparam int CW      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(WIN_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(WIN_SIZE - 1);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          hit, is_end;

    logic [WIN_SIZE-2:0][DIN_WIDTH-1:0] tap;
    logic [WIN_SIZE-1:0][DIN_WIDTH-1:0] col_in;
    logic [WIN_SQR-1:0][DIN_WIDTH-1:0]  win_q, win_nxt;
    logic                               vld_q, last_q;

    // A start-of-frame pixel is (0,0) no matter where the counters were.
    assign cur_col = pix_sof ? '0 : col;
    assign cur_row = pix_sof ? '0 : row;
    assign hit     = (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
    assign is_end  = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

    genvar g;
    generate
        for (g = 0; g < WIN_SIZE - 1; g++) begin : g_lb
            logic [DIN_WIDTH-1:0] lb_in;
            if (g == 0) begin : g_head
                assign lb_in = pix;
            end else begin : g_chain
                assign lb_in = tap[g-1];
            end
            conv_line_buf #(.DIN_WIDTH(DIN_WIDTH), .DEPTH(IMG_WIDTH)) u_lb (
                .clk  (clk),
                .en   (pix_vld),
                .din  (lb_in),
                .dout (tap[g])
            );
        end

        // Bottom window row takes the live pixel; higher rows take deeper taps.
        for (g = 0; g < WIN_SIZE; g++) begin : g_col
            if (g == WIN_SIZE - 1) begin : g_live
                assign col_in[g] = pix;
            end else begin : g_tap
                assign col_in[g] = tap[WIN_SIZE-2-g];
            end
        end
    endgenerate

    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                if (c == WIN_SIZE - 1) win_nxt[r*WIN_SIZE+c] = col_in[r];
                else                   win_nxt[r*WIN_SIZE+c] = win_q[r*WIN_SIZE+c+1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col    <= '0;
            row    <= '0;
            win_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= pix_vld && hit;
            last_q <= pix_vld && hit && is_end;
            if (pix_vld) begin
                win_q <= win_nxt;
                if (cur_col == COL_MAX) begin
                    col <= '0;
                    row <= (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end
        end
    end

    assign win_vld  = vld_q;
    assign win_last = last_q;
    assign win      = win_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 image with 3x3 windows.
// Windows are captured by a monitor and compared against a pixel-pattern model.

module tb_conv_window_gen;
    localparam int DW = 8;
    localparam int WS = 3;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int NWIN = (IW - WS + 1) * (IH - WS + 1);

    typedef logic [WS*WS-1:0][DW-1:0] win_t;

    typedef struct {
        logic [7:0] base;
        int         gap;
        bit         ff;
        win_t       exp_first;
        logic [7:0] exp_last_el;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pix_vld = 1'b0;
    logic          pix_sof = 1'b0;
    logic [DW-1:0] pix = '0;
    logic          win_vld;
    win_t          win;
    logic          win_last;

    int checks = 0;
    int errors = 0;

    win_t win_q[$];
    bit   last_q[$];
    bit   orph_q[$];
    int   cnt_q[$];
    bit   acc_q = 1'b0;
    int   acc_cnt = 0;

    conv_window_gen #(.DIN_WIDTH(DW), .WIN_SIZE(WS), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_vld  (pix_vld),
        .pix_sof  (pix_sof),
        .pix      (pix),
        .win_vld  (win_vld),
        .win      (win),
        .win_last (win_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        acc_q <= pix_vld;
        if (pix_vld) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (win_vld) begin
            win_q.push_back(win);
            last_q.push_back(win_last);
            orph_q.push_back(!acc_q);
            cnt_q.push_back(acc_cnt);
        end
    end

    function automatic win_t exp_win(input logic [7:0] base, input int r0, input int c0, input bit ff);
        win_t w;
        for (int i = 0; i < WS * WS; i++)
            w[i] = ff ? 8'hFF : 8'(int'(base) + (r0 + i / WS) * 16 + c0 + i % WS);
        return w;
    endfunction

    task automatic send_pix(input logic [7:0] v, input bit sof, input int gap);
        for (int k = 0; k < 3 && int'($urandom_range(99)) < gap; k++) begin
            @(posedge clk); #1;
        end
        pix_vld = 1'b1; pix_sof = sof; pix = v;
        @(posedge clk); #1;
        pix_vld = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic send_pixels(input logic [7:0] base, input bit sof, input int gap, input bit ff, input int n);
        for (int i = 0; i < n; i++)
            send_pix(ff ? 8'hFF : 8'(int'(base) + (i / IW) * 16 + i % IW), sof && i == 0, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag, input int off, input int n);
        checks++;
        if (win_q.size() - off != n) begin
            errors++;
            $display("FAIL %s count: got %0d windows, expected %0d", tag, win_q.size() - off, n);
        end
    endtask

    task automatic check_windows(input string tag, input logic [7:0] base, input int off, input bit ff);
        for (int i = 0; i < NWIN; i++) begin
            win_t e;
            e = exp_win(base, i / (IW - WS + 1), i % (IW - WS + 1), ff);
            checks++;
            if (off + i >= win_q.size()) begin
                errors++;
                $display("FAIL %s win%0d: missing, expected %h", tag, i, e);
            end else if (win_q[off+i] !== e || last_q[off+i] !== (i == NWIN - 1) || orph_q[off+i]) begin
                errors++;
                $display("FAIL %s win%0d: got %h last=%0b orphan=%0b, expected %h last=%0b orphan=0",
                         tag, i, win_q[off+i], last_q[off+i], orph_q[off+i], e, i == NWIN - 1);
            end
        end
    endtask

    vec_t tbl[4];

    initial begin
        int off, start;

        tbl[0] = '{8'h00, 0,  1'b0, 72'h22_21_20_12_11_10_02_01_00, 8'h34};
        tbl[1] = '{8'h00, 50, 1'b0, 72'h22_21_20_12_11_10_02_01_00, 8'h34};
        tbl[2] = '{8'h80, 50, 1'b0, 72'hA2_A1_A0_92_91_90_82_81_80, 8'hB4};
        tbl[3] = '{8'h00, 0,  1'b1, {9{8'hFF}},                     8'hFF};

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        idle(3);
        checks++;
        if (win_vld !== 1'b0 || win_last !== 1'b0 || win !== '0) begin
            errors++;
            $display("FAIL reset: got vld=%b last=%b win=%h, expected 0 0 0", win_vld, win_last, win);
        end
        reset_n = 1'b1;
        idle(2);

        for (int t = 0; t < 4; t++) begin
            off = win_q.size();
            start = acc_cnt;
            send_pixels(tbl[t].base, 1'b1, tbl[t].gap, tbl[t].ff, IW * IH);
            idle(2);
            check_count($sformatf("vec%0d", t), off, NWIN);
            checks++;
            if (win_q.size() <= off || win_q[off] !== tbl[t].exp_first) begin
                errors++;
                $display("FAIL vec%0d first: got %h, expected %h", t,
                         (win_q.size() > off) ? win_q[off] : win_t'('x), tbl[t].exp_first);
            end
            checks++;
            if (win_q.size() < off + NWIN || win_q[off+NWIN-1][WS*WS-1] !== tbl[t].exp_last_el) begin
                errors++;
                $display("FAIL vec%0d last_el: got %h, expected %h", t,
                         (win_q.size() >= off + NWIN) ? win_q[off+NWIN-1][WS*WS-1] : 8'hxx, tbl[t].exp_last_el);
            end
            checks++;
            if (win_q.size() <= off || cnt_q[off] - start != 13) begin
                errors++;
                $display("FAIL vec%0d latency: first window after pixel %0d, expected 13", t,
                         (win_q.size() > off) ? cnt_q[off] - start : -1);
            end
            check_windows($sformatf("vec%0d", t), tbl[t].base, off, tbl[t].ff);
        end

        // Two frames with no gap; the second relies on counter wrap, not sof.
        off = win_q.size();
        send_pixels(8'h00, 1'b1, 0, 1'b0, IW * IH);
        send_pixels(8'h80, 1'b0, 0, 1'b0, IW * IH);
        idle(2);
        check_count("b2b", off, 2 * NWIN);
        check_windows("b2b_f1", 8'h00, off, 1'b0);
        check_windows("b2b_f2", 8'h80, off + NWIN, 1'b0);

        // Restart mid-frame at (2,3).
        send_pixels(8'h00, 1'b1, 0, 1'b0, 2 * IW + 3);
        idle(2);
        off = win_q.size();
        send_pixels(8'h80, 1'b1, 0, 1'b0, IW * IH);
        idle(2);
        check_count("sof_mid", off, NWIN);
        check_windows("sof_mid", 8'h80, off, 1'b0);

        // Reset while a window is being presented at (3,2).
        send_pixels(8'h00, 1'b1, 0, 1'b0, 3 * IW + 3);
        checks++;
        if (win_vld !== 1'b1 || win !== exp_win(8'h00, 1, 0, 1'b0)) begin
            errors++;
            $display("FAIL pre_reset: got vld=%b win=%h, expected 1 %h", win_vld, win, exp_win(8'h00, 1, 0, 1'b0));
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (win_vld !== 1'b0 || win_last !== 1'b0 || win !== '0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b last=%b win=%h, expected 0 0 0", win_vld, win_last, win);
        end
        idle(2);
        reset_n = 1'b1;
        idle(1);
        off = win_q.size();
        send_pixels(8'h00, 1'b0, 0, 1'b0, IW * IH);
        idle(2);
        check_count("post_reset", off, NWIN);
        check_windows("post_reset", 8'h00, off, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
